// File: rtl/wbuf_mem_mgr.sv
// Data/instruction memory manager: WB_DEPTH-entry posted-write buffer in front of a
// byte-enabled dual-port RAM with per-lane load forwarding. Optional: MEM_MGR_FLUSH_EN.
module wbuf_mem_mgr #(
  parameter int WIDTH     = 32,
  parameter int MEM_WORDS = 'h1000,
  parameter int WB_DEPTH  = 4,
  parameter int BYTES     = WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [WIDTH-1:0]            wr_addr,
  input  logic                        we,
  input  logic [2:0]                  wr_bytes,
  input  logic [WIDTH-1:0]            wr_data,
  output logic                        wr_misaligned,
  input  logic [WIDTH-1:0]            rd_addr,
  input  logic                        re,
  input  logic [2:0]                  rd_bytes,
  input  logic                        rd_unsigned,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        rd_misaligned,
  output logic                        must_wait,
  input  logic [WIDTH-1:0]            inst_addr,
  output logic [WIDTH-1:0]            inst_data,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_empty
`ifdef MEM_MGR_FLUSH_EN
  ,
  input  logic                        flush,
  output logic                        flush_done
`endif
);
  localparam int LB = $clog2(BYTES);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0]    MAXSZ = 3'(LB);
  localparam logic [CW-1:0] FULL  = CW'(WB_DEPTH);

  typedef struct packed {
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] data;
    logic [BYTES-1:0] be;
  } ent_t;

  logic [WIDTH-1:0] mem [MEM_WORDS];
  ent_t             wb_q [WB_DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q, inst_q, inst_d;

  logic wr_mis, rd_mis, wr_ok, rd_ok, full, empty, flushing;
  logic stall, ld_acc, st_acc, drain, wr_en;
  ent_t st_ent, hd;
  logic [AW-1:0]    ld_idx, ib_idx;
  logic [LB-1:0]    ld_off, st_off;
  logic [WIDTH-1:0] merged, shifted, ld_val;
  logic [2:0]       ld_sz;
  int               ld_bits;
  logic             unused_bits;

  function automatic logic misal(input logic [WIDTH-1:0] a, input logic [2:0] sz);
    logic [WIDTH-1:0] m;
    m = (WIDTH'(1) << sz) - WIDTH'(1);
    return (sz > MAXSZ) || ((a & m) != '0);
  endfunction

  function automatic logic [BYTES-1:0] lane_mask(input logic [LB-1:0] off, input logic [2:0] sz);
    logic [BYTES-1:0] m;
    for (int b = 0; b < BYTES; b++)
      m[b] = (b >= int'(off)) && (b < int'(off) + (1 << sz));
    return m;
  endfunction

`ifdef MEM_MGR_FLUSH_EN
  logic flush_d1_q, flush_done_q;
  assign flushing   = flush;
  assign flush_done = flush_done_q;
`else
  assign flushing = 1'b0;
`endif

  assign wr_mis = we && misal(wr_addr, wr_bytes);
  assign rd_mis = re && misal(rd_addr, rd_bytes);
  assign wr_ok  = we && !wr_mis;
  assign rd_ok  = re && !rd_mis;
  assign full   = (cnt_q == FULL);
  assign empty  = (cnt_q == '0);
  // A full buffer with a pending store forces a drain and blocks the whole request.
  assign stall  = (wr_ok && full) || flushing;
  assign ld_acc = rd_ok && !stall;
  assign st_acc = wr_ok && !full && !flushing;
  assign drain  = !empty && !ld_acc;
  assign wr_en  = drain && !clr;
  assign hd     = wb_q[head_q];

  assign st_off     = wr_addr[LB-1:0];
  assign st_ent.idx  = wr_addr[LB +: AW];
  assign st_ent.data = wr_data << {st_off, 3'b000};
  assign st_ent.be   = lane_mask(st_off, wr_bytes);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({st_acc, drain})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Lane merge: RAM, then buffer entries oldest to newest, then the same-cycle store.
  assign ld_idx = rd_addr[LB +: AW];
  assign ld_off = rd_addr[LB-1:0];
  always_comb begin
    merged = mem[ld_idx];
    for (int k = 0; k < WB_DEPTH; k++)
      if (CW'(k) < cnt_q && wb_q[head_q + PW'(k)].idx == ld_idx)
        for (int b = 0; b < BYTES; b++)
          if (wb_q[head_q + PW'(k)].be[b])
            merged[8*b +: 8] = wb_q[head_q + PW'(k)].data[8*b +: 8];
    if (st_acc && st_ent.idx == ld_idx)
      for (int b = 0; b < BYTES; b++)
        if (st_ent.be[b]) merged[8*b +: 8] = st_ent.data[8*b +: 8];
  end

  assign shifted = merged >> {ld_off, 3'b000};
  assign ld_sz   = (rd_bytes > MAXSZ) ? MAXSZ : rd_bytes;
  assign ld_bits = 8 << ld_sz;
  always_comb begin
    ld_val = shifted;
    for (int i = 0; i < WIDTH; i++)
      if (i >= ld_bits) ld_val[i] = rd_unsigned ? 1'b0 : shifted[ld_bits-1];
  end

  // Port B is write-first against a same-cycle drain to the same word.
  assign ib_idx = inst_addr[LB +: AW];
  always_comb begin
    inst_d = mem[ib_idx];
    if (wr_en && hd.idx == ib_idx)
      for (int b = 0; b < BYTES; b++)
        if (hd.be[b]) inst_d[8*b +: 8] = hd.data[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < BYTES; b++)
        if (hd.be[b]) mem[hd.idx][8*b +: 8] <= hd.data[8*b +: 8];
    inst_q <= inst_d;
    if (!clr && st_acc) wb_q[tail_q] <= st_ent;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (st_acc) tail_q <= tail_q + PW'(1);
      if (drain)  head_q <= head_q + PW'(1);
      cnt_q      <= cnt_d;
      rd_valid_q <= ld_acc;
      if (ld_acc) rd_data_q <= ld_val;
    end
  end

`ifdef MEM_MGR_FLUSH_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      flush_d1_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_d1_q   <= flush;
      flush_done_q <= flush && (cnt_d == '0) && (!empty || !flush_d1_q);
    end
  end
`endif

  assign wr_misaligned = wr_mis;
  assign rd_misaligned = rd_mis;
  assign must_wait     = stall;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign inst_data     = inst_q;
  assign wb_count      = cnt_q;
  assign wb_empty      = empty;
  assign unused_bits   = ^{inst_addr[LB-1:0], inst_addr[WIDTH-1:LB+AW]};

`ifndef SYNTHESIS
  a_cnt:  assert property (@(posedge clk) disable iff (clr) cnt_q <= FULL);
  a_enq:  assert property (@(posedge clk) disable iff (clr) st_acc |-> !full);
  a_rdsz: assert property (@(posedge clk) disable iff (clr) re |-> rd_bytes <= MAXSZ);
  a_wrsz: assert property (@(posedge clk) disable iff (clr) we |-> wr_bytes <= MAXSZ);
`endif
endmodule
